// File: rtl/hub_pkg.sv
// Shared types, defaults and helpers for the repeater-hub transmit arbiter.
package hub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    TRUNC = 2'd2,
    IFG   = 2'd3
  } state_e;

  localparam int IFG_CYCLES_DEF = 12;
  localparam int MAX_LEN_DEF    = 1522;
  localparam int CNT_W          = 16;
  localparam int LEN_W          = 16;

  // Number of set bits in a request vector of up to eight ports.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NPORT = 4,
  parameter int PW    = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [NPORT-1:0] grant_oh,
  output logic [PW-1:0]    grant_idx
);

  localparam int SW = PW + 1;

  logic [SW-1:0] sum_s;
  logic [PW-1:0] idx_s;
  logic          found_s;

  // Scan from ptr upward with wrap; the first requester wins.
  always_comb begin
    grant_oh  = {NPORT{1'b0}};
    grant_idx = {PW{1'b0}};
    found_s   = 1'b0;
    sum_s     = {SW{1'b0}};
    idx_s     = {PW{1'b0}};
    for (int k = 0; k < NPORT; k++) begin
      sum_s = {1'b0, ptr} + SW'(k);
      if (sum_s >= SW'(NPORT)) begin
        sum_s = sum_s - SW'(NPORT);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PW-1:0];
      if (!found_s && req[idx_s]) begin
        found_s         = 1'b1;
        grant_oh[idx_s] = 1'b1;
        grant_idx       = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/hub_tx_arbiter.sv
// Frame-level round-robin arbiter feeding the shared hub transmit datapath,
// with collision flagging, inter-frame gap and over-length truncation.
module hub_tx_arbiter
  import hub_pkg::*;
#(
  parameter int NPORT      = 4,
  parameter int IFG_CYCLES = IFG_CYCLES_DEF,
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int PW         = $clog2(NPORT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NPORT-1:0]   rx_dv,
  input  logic [NPORT-1:0]   rx_er,
  input  logic [8*NPORT-1:0] rxd,
  output logic               tx_en,
  output logic               tx_er,
  output logic [7:0]         txd,
  output logic [PW-1:0]      tx_src,
  output logic [NPORT-1:0]   col,
  output logic [CNT_W-1:0]   fwd_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int IW = $clog2(IFG_CYCLES + 1);

  state_e           state_r, state_s;
  logic [NPORT-1:0] rx_dv_q_r, req_s, pick_oh_s, fwd_oh_s, owner_oh_s;
  logic             armed_r;
  logic [PW-1:0]    owner_r, rr_ptr_r, pick_idx_s, fwd_idx_s, ptr_nx_s;
  logic [LEN_W-1:0] len_r, len_s;
  logic [IW-1:0]    ifg_cnt_r, ifg_cnt_s;
  logic             grant_s, fwd_s, trunc_s;
  logic [7:0]       byte_s;
  logic [3:0]       drops_s;
  logic [CNT_W:0]   fwd_sum_s, drop_sum_s;

  // armed_r masks the first cycle after reset so a port already mid-frame needs a fresh edge.
  assign req_s  = armed_r ? (rx_dv & ~rx_dv_q_r) : {NPORT{1'b0}};
  assign tx_src = owner_r;

  rr_pick #(
    .NPORT (NPORT),
    .PW    (PW)
  ) u_rr_pick (
    .req       (req_s),
    .ptr       (rr_ptr_r),
    .grant_oh  (pick_oh_s),
    .grant_idx (pick_idx_s)
  );

  // Next-state, forwarding decision and per-frame counters.
  always_comb begin
    state_s   = state_r;
    len_s     = len_r;
    ifg_cnt_s = ifg_cnt_r;
    grant_s   = 1'b0;
    fwd_s     = 1'b0;
    trunc_s   = 1'b0;
    fwd_idx_s = owner_r;
    fwd_oh_s  = {NPORT{1'b0}};
    case (state_r)
      IDLE: begin
        if (|req_s) begin
          grant_s   = 1'b1;
          fwd_s     = 1'b1;
          fwd_idx_s = pick_idx_s;
          fwd_oh_s  = pick_oh_s;
          len_s     = LEN_W'(1);
          state_s   = FWD;
        end else begin
          state_s = IDLE;
        end
      end
      FWD: begin
        if (rx_dv[owner_r]) begin
          fwd_s    = 1'b1;
          fwd_oh_s = owner_oh_s;
          // len_r counts bytes already sent, so this byte is number len_r+1.
          if (len_r == LEN_W'(MAX_LEN - 1)) begin
            trunc_s = 1'b1;
            state_s = TRUNC;
          end else begin
            len_s = len_r + LEN_W'(1);
          end
        end else begin
          ifg_cnt_s = IW'(IFG_CYCLES - 1);
          state_s   = IFG;
        end
      end
      TRUNC: begin
        if (!rx_dv[owner_r]) begin
          ifg_cnt_s = IW'(IFG_CYCLES - 1);
          state_s   = IFG;
        end else begin
          state_s = TRUNC;
        end
      end
      IFG: begin
        ifg_cnt_s = ifg_cnt_r - IW'(1);
        if (ifg_cnt_r <= IW'(1)) begin
          state_s = IDLE;
        end else begin
          state_s = IFG;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Pointer advance, owner decode, byte select and saturating counter sums.
  always_comb begin
    if (pick_idx_s == PW'(NPORT - 1)) begin
      ptr_nx_s = {PW{1'b0}};
    end else begin
      ptr_nx_s = pick_idx_s + PW'(1);
    end
    owner_oh_s = {{(NPORT-1){1'b0}}, 1'b1} << owner_r;
    byte_s     = rxd[{fwd_idx_s, 3'b000} +: 8];
    drops_s    = popcount8(8'(req_s)) - {3'd0, grant_s};
    fwd_sum_s  = {1'b0, fwd_cnt} + {{CNT_W{1'b0}}, grant_s};
    drop_sum_s = {1'b0, drop_cnt} + {{(CNT_W-3){1'b0}}, drops_s};
  end

  // State, frame bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rx_dv_q_r <= {NPORT{1'b0}};
      armed_r   <= 1'b0;
      owner_r   <= {PW{1'b0}};
      rr_ptr_r  <= {PW{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      ifg_cnt_r <= {IW{1'b0}};
      tx_en     <= 1'b0;
      tx_er     <= 1'b0;
      txd       <= 8'd0;
      col       <= {NPORT{1'b0}};
      fwd_cnt   <= {CNT_W{1'b0}};
      drop_cnt  <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      rx_dv_q_r <= rx_dv;
      armed_r   <= 1'b1;
      len_r     <= len_s;
      ifg_cnt_r <= ifg_cnt_s;
      if (grant_s) begin
        owner_r  <= pick_idx_s;
        rr_ptr_r <= ptr_nx_s;
      end else begin
        owner_r  <= owner_r;
        rr_ptr_r <= rr_ptr_r;
      end
      tx_en    <= fwd_s;
      tx_er    <= fwd_s & (rx_er[fwd_idx_s] | trunc_s);
      txd      <= fwd_s ? byte_s : 8'd0;
      col      <= rx_dv & ~fwd_oh_s;
      fwd_cnt  <= fwd_sum_s[CNT_W] ? {CNT_W{1'b1}} : fwd_sum_s[CNT_W-1:0];
      drop_cnt <= drop_sum_s[CNT_W] ? {CNT_W{1'b1}} : drop_sum_s[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_hub_tx_arbiter.sv
// Directed bench for hub_tx_arbiter: arbitration, collisions, gap, truncation, reset.
module tb_hub_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rx_dv, rx_er;
  logic [31:0] rxd;
  logic        tx_en, tx_er;
  logic [7:0]  txd;
  logic [1:0]  tx_src;
  logic [3:0]  col;
  logic [15:0] fwd_cnt, drop_cnt;
  int          n_chk  = 0;
  int          n_pass = 0;

  always #4 clk = ~clk;

  hub_tx_arbiter #(
    .NPORT      (4),
    .IFG_CYCLES (12),
    .MAX_LEN    (1522),
    .PW         (2)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_dv    (rx_dv),
    .rx_er    (rx_er),
    .rxd      (rxd),
    .tx_en    (tx_en),
    .tx_er    (tx_er),
    .txd      (txd),
    .tx_src   (tx_src),
    .col      (col),
    .fwd_cnt  (fwd_cnt),
    .drop_cnt (drop_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_dv = 4'd0;
    rx_er = 4'd0;
    rxd   = 32'd0;
    repeat (n) cyc();
  endtask

  function automatic logic [31:0] lane(input int p, input logic [7:0] v);
    return {24'd0, v} << (8 * p);
  endfunction

  initial begin
    rst_n = 1'b0;
    rx_dv = 4'd0;
    rx_er = 4'd0;
    rxd   = 32'd0;
    repeat (2) cyc();
    check_val("rst_tx_en", 32'(tx_en), 32'd0);
    check_val("rst_tx_er", 32'(tx_er), 32'd0);
    check_val("rst_txd", 32'(txd), 32'd0);
    check_val("rst_tx_src", 32'(tx_src), 32'd0);
    check_val("rst_col", 32'(col), 32'd0);
    check_val("rst_fwd_cnt", 32'(fwd_cnt), 32'd0);
    check_val("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Ports 0 and 3 start together with rr_ptr=0: port 0 wins.
    for (int b = 0; b < 8; b++) begin
      rx_dv = 4'b1001;
      rxd   = lane(0, 8'(8'h10 + b)) | lane(3, 8'(8'h30 + b));
      cyc();
      check_val("rr0_txd", 32'(txd), 32'(8'h10 + b));
      check_val("rr0_tx_en", 32'(tx_en), 32'd1);
      check_val("rr0_src", 32'(tx_src), 32'd0);
      check_val("rr0_col", 32'(col), 32'h8);
    end
    check_val("rr0_drop", 32'(drop_cnt), 32'd1);
    check_val("rr0_fwd", 32'(fwd_cnt), 32'd1);
    idle(1);
    check_val("rr0_end_tx_en", 32'(tx_en), 32'd0);
    check_val("rr0_end_col", 32'(col), 32'd0);
    idle(14);

    // Same pair again: rr_ptr=1 so port 3 wins.
    for (int b = 0; b < 8; b++) begin
      rx_dv = 4'b1001;
      rxd   = lane(0, 8'(8'h10 + b)) | lane(3, 8'(8'h30 + b));
      cyc();
      check_val("rr1_txd", 32'(txd), 32'(8'h30 + b));
      check_val("rr1_src", 32'(tx_src), 32'd3);
      check_val("rr1_col", 32'(col), 32'h1);
    end
    check_val("rr1_drop", 32'(drop_cnt), 32'd2);
    check_val("rr1_fwd", 32'(fwd_cnt), 32'd2);
    idle(15);

    // Single 64-byte frame on port 2.
    for (int b = 0; b < 64; b++) begin
      rx_dv = 4'b0100;
      rxd   = lane(2, 8'(b));
      cyc();
      check_val("p2_txd", 32'(txd), 32'(b));
      check_val("p2_tx_en", 32'(tx_en), 32'd1);
      check_val("p2_src", 32'(tx_src), 32'd2);
      check_val("p2_col", 32'(col), 32'd0);
    end
    idle(1);
    check_val("p2_end_tx_en", 32'(tx_en), 32'd0);
    check_val("p2_fwd", 32'(fwd_cnt), 32'd3);
    check_val("p2_drop", 32'(drop_cnt), 32'd2);
    idle(14);

    // Port 0 frame, then port 1 starts 5 cycles into the gap and is never granted.
    for (int b = 0; b < 10; b++) begin
      rx_dv = 4'b0001;
      rxd   = lane(0, 8'(8'hA0 + b));
      cyc();
      check_val("ifg_p0_txd", 32'(txd), 32'(8'hA0 + b));
    end
    check_val("ifg_p0_fwd", 32'(fwd_cnt), 32'd4);
    idle(5);
    for (int b = 0; b < 20; b++) begin
      rx_dv = 4'b0010;
      rxd   = lane(1, 8'(b));
      cyc();
      check_val("ifg_p1_tx_en", 32'(tx_en), 32'd0);
      check_val("ifg_p1_col", 32'(col), 32'h2);
    end
    check_val("ifg_p1_drop", 32'(drop_cnt), 32'd3);
    check_val("ifg_p1_fwd", 32'(fwd_cnt), 32'd4);
    idle(15);

    // Gap boundary: a start 11 cycles after tx_en falls is dropped, 12 is granted.
    for (int b = 0; b < 4; b++) begin
      rx_dv = 4'b0001;
      rxd   = lane(0, 8'(8'hE0 + b));
      cyc();
      check_val("gap_p0_txd", 32'(txd), 32'(8'hE0 + b));
    end
    check_val("gap_p0_fwd", 32'(fwd_cnt), 32'd5);
    idle(11);
    rx_dv = 4'b1000;
    rxd   = lane(3, 8'h55);
    cyc();
    check_val("gap_early_tx_en", 32'(tx_en), 32'd0);
    check_val("gap_early_drop", 32'(drop_cnt), 32'd4);
    rx_dv = 4'b1100;
    rxd   = lane(3, 8'h56) | lane(2, 8'h66);
    cyc();
    check_val("gap_ok_tx_en", 32'(tx_en), 32'd1);
    check_val("gap_ok_src", 32'(tx_src), 32'd2);
    check_val("gap_ok_txd", 32'(txd), 32'h66);
    check_val("gap_ok_col", 32'(col), 32'h8);
    check_val("gap_ok_fwd", 32'(fwd_cnt), 32'd6);
    rxd = lane(3, 8'h57) | lane(2, 8'h67);
    cyc();
    check_val("gap_ok_txd2", 32'(txd), 32'h67);
    idle(15);

    // 1600-byte frame on port 0 is cut after byte 1522.
    for (int b = 0; b < 1600; b++) begin
      rx_dv = 4'b0001;
      rxd   = lane(0, 8'(b));
      cyc();
      if (b < 1522) begin
        check_val("trunc_tx_en", 32'(tx_en), 32'd1);
        check_val("trunc_txd", 32'(txd), 32'(b % 256));
        check_val("trunc_tx_er", 32'(tx_er), 32'(b == 1521));
      end else begin
        check_val("trunc_cut_tx_en", 32'(tx_en), 32'd0);
        check_val("trunc_cut_tx_er", 32'(tx_er), 32'd0);
      end
    end
    check_val("trunc_fwd", 32'(fwd_cnt), 32'd7);
    for (int k = 0; k < 12; k++) begin
      idle(1);
      check_val("trunc_ifg_tx_en", 32'(tx_en), 32'd0);
    end
    idle(3);

    // rx_er on byte 10 of a port 1 frame maps to exactly one tx_er cycle.
    for (int b = 0; b < 20; b++) begin
      rx_dv = 4'b0010;
      rx_er = (b == 9) ? 4'b0010 : 4'b0000;
      rxd   = lane(1, 8'(8'h40 + b));
      cyc();
      check_val("er_tx_er", 32'(tx_er), 32'(b == 9));
      check_val("er_txd", 32'(txd), 32'(8'h40 + b));
      check_val("er_src", 32'(tx_src), 32'd1);
    end
    check_val("er_fwd", 32'(fwd_cnt), 32'd8);
    idle(15);

    // Asynchronous reset at byte 30 of a port 2 frame, rx_dv held high across it.
    for (int b = 0; b < 30; b++) begin
      rx_dv = 4'b0100;
      rxd   = lane(2, 8'(8'h80 + b));
      cyc();
    end
    check_val("rst_pre_txd", 32'(txd), 32'h9D);
    check_val("rst_pre_tx_en", 32'(tx_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_tx_en", 32'(tx_en), 32'd0);
    check_val("arst_txd", 32'(txd), 32'd0);
    check_val("arst_src", 32'(tx_src), 32'd0);
    check_val("arst_col", 32'(col), 32'd0);
    check_val("arst_fwd", 32'(fwd_cnt), 32'd0);
    check_val("arst_drop", 32'(drop_cnt), 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rxd = lane(2, 8'(8'h90 + k));
      cyc();
      check_val("post_rst_tx_en", 32'(tx_en), 32'd0);
      check_val("post_rst_col", 32'(col), 32'h4);
      check_val("post_rst_fwd", 32'(fwd_cnt), 32'd0);
    end
    idle(1);
    for (int b = 0; b < 5; b++) begin
      rx_dv = 4'b0100;
      rxd   = lane(2, 8'(8'hC0 + b));
      cyc();
      check_val("rearm_txd", 32'(txd), 32'(8'hC0 + b));
      check_val("rearm_tx_en", 32'(tx_en), 32'd1);
      check_val("rearm_src", 32'(tx_src), 32'd2);
    end
    check_val("rearm_fwd", 32'(fwd_cnt), 32'd1);
    check_val("rearm_drop", 32'(drop_cnt), 32'd0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hub_tx_arbiter.md
# hub_tx_arbiter

Frame-level arbiter for the multi-port repeater hub. Each port's RGMII receive path has already been converted to byte-wide GMII in the core clock domain. The block grants the shared transmit datapath to one receiving port per frame, round-robin, and forwards that port's bytes with one cycle of latency. It flags collisions on ports that lose, enforces the inter-frame gap, and truncates over-length frames.

## Interface
Parameters:
- NPORT, 4, number of receive ports (2..8)
- IFG_CYCLES, 12, idle cycles forced between forwarded frames
- MAX_LEN, 1522, maximum forwarded bytes per frame
- PW, $clog2(NPORT), port index width

Ports:
- clk  in  1  core byte clock (125 MHz)
- rst_n  in  1  asynchronous, active-low reset
- rx_dv  in  NPORT  per-port data valid
- rx_er  in  NPORT  per-port receive error
- rxd  in  8*NPORT  per-port data byte; port i on bits [8i+7:8i]
- tx_en  out  1  shared transmit enable
- tx_er  out  1  shared transmit error
- txd  out  8  shared transmit byte
- tx_src  out  PW  index of the port currently owning transmit
- col  out  NPORT  per-port collision indication
- fwd_cnt  out  16  forwarded frames, saturating
- drop_cnt  out  16  frames that lost arbitration, saturating

## Operation
- Edge detect: rx_dv_q registers rx_dv. A start-of-frame request is req[i] = rx_dv[i] & ~rx_dv_q[i].
- States:
  - IDLE: if req is nonzero, grant the first requesting port at or after rr_ptr (wrapping). Then owner <= grant, rr_ptr <= grant+1 mod NPORT, len <= 1, go to FWD. The granted byte is forwarded in this same cycle.
  - FWD: while rx_dv[owner] is high, forward the byte and increment len. When rx_dv[owner] goes low, go to IFG and load ifg_cnt <= IFG_CYCLES-1. When rx_dv[owner] is high and len == MAX_LEN, forward that byte with tx_er=1 and go to TRUNC.
  - TRUNC: nothing is forwarded. When rx_dv[owner] goes low, go to IFG.
  - IFG: decrement ifg_cnt. When it reaches 0, go to IDLE.
- Forwarded byte: txd <= rxd[owner], tx_en <= 1, tx_er <= rx_er[owner] (forced to 1 on the truncation byte).
- Requests that arrive in FWD, TRUNC or IFG are never granted later in the same frame. A port becomes eligible again only on its next rising edge of rx_dv.
- col[i] <= rx_dv[i] & ~(port i forwarded this cycle).
- drop_cnt increments once for each req[i] that is not granted, including multiple in one cycle (add popcount). fwd_cnt increments on each grant. Both counters saturate at 0xFFFF.
- When several ports request in the same IDLE cycle, exactly one is granted and the others each count as a drop.

## Timing
- Reset values: tx_en=0, tx_er=0, txd=0, tx_src=0, col=0, fwd_cnt=0, drop_cnt=0. Internally: state=IDLE, rr_ptr=0, rx_dv_q=0.
- Reset asserted mid-frame clears all of the above immediately. After release, a port whose rx_dv is still high is not granted until it produces a new rising edge.
- All outputs are registered. rxd presented in cycle t appears on txd in cycle t+1.
- The frame's last byte appears on txd in cycle t+1. tx_en falls in the cycle after that. The next grant can occur no earlier than IFG_CYCLES cycles after tx_en falls.
- The truncation byte is byte MAX_LEN and carries tx_er=1. tx_en falls in the following cycle.
- tx_src holds the owner from the grant until the next grant.

## Structure
- Shared package hub_pkg holds: state enum (IDLE, FWD, TRUNC, IFG), default IFG_CYCLES and MAX_LEN, and the counter width constant.
- One sub-module, rr_pick: combinational round-robin first-set finder with NPORT request bits and PW pointer bits in, one-hot grant and index out. The datapath and FSM stay in hub_tx_arbiter.

## Test plan
- Single frame: port 2 sends 64 bytes 0x00..0x3F. Expect txd to repeat them with 1-cycle latency, tx_src=2, fwd_cnt=1, col=0.
- Simultaneous start on ports 0 and 3 with rr_ptr=0: expect port 0 forwarded, col[3]=1 for all of port 3's frame, drop_cnt=1. Repeat with both ports again: expect port 3 granted (rr_ptr=1).
- Port 1 starts 5 cycles into IFG after a port 0 frame: expect it never granted, col[1] high for its duration, drop_cnt incremented. Next grant no earlier than 12 idle cycles.
- 1600-byte frame on port 0: expect 1522 bytes on txd, tx_er=1 on byte 1522 only, tx_en low until IFG completes after rx_dv[0] falls.
- Reset asserted at byte 30 of a port 2 frame with rx_dv[2] held high: expect outputs zeroed asynchronously, no forwarding after release until port 2 deasserts and reasserts rx_dv.
- rx_er[1] pulsed on byte 10 of a forwarded port 1 frame: expect tx_er=1 on exactly the corresponding txd cycle.
